// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic tile engine: FSM state encoding,
// flush length and the clamping adder used when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } tile_state_t;

    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    // Operands arrive already sign/zero-extended to 64 bits; the result is clamped
    // to the signed or unsigned range of a width-bit accumulator.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic is_signed, input int width);
        logic signed [65:0] sum;
        logic signed [65:0] hi;
        logic signed [65:0] lo;
        if (is_signed) begin
            sum = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
            hi  = (66'sd1 <<< (width - 1)) - 66'sd1;
            lo  = -(66'sd1 <<< (width - 1));
        end else begin
            sum = $signed({2'b00, a}) + $signed({2'b00, b});
            hi  = (66'sd1 <<< width) - 66'sd1;
            lo  = '0;
        end
        if (sum > hi)
            sum = hi;
        else if (sum < lo)
            sum = lo;
        return sum[63:0];
    endfunction

endpackage

// File: rtl/tile_pe.sv
// Output-stationary MAC cell: forwards x right, w down, en/clr tokens with x.
// Saturating accumulation is built only when SYSTOLIC_SAT_EN is defined.
module tile_pe
    import systolic_pkg::*;
#(
    parameter int IP_WIDTH = 8,
    parameter int OP_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode_signed,
    input  logic [IP_WIDTH-1:0] x_in,
    input  logic [IP_WIDTH-1:0] w_in,
    input  logic                en_in,
    input  logic                clr_in,
    output logic [IP_WIDTH-1:0] x_out,
    output logic [IP_WIDTH-1:0] w_out,
    output logic                en_out,
    output logic                clr_out,
    output logic [OP_WIDTH-1:0] acc
);

    logic signed [2*IP_WIDTH-1:0] prod_s;
    logic        [2*IP_WIDTH-1:0] prod_u;
    logic        [OP_WIDTH-1:0]   prod_ext;
    logic        [OP_WIDTH-1:0]   acc_nxt;

    always_comb begin
        prod_s   = $signed({{IP_WIDTH{x_in[IP_WIDTH-1]}}, x_in}) *
                   $signed({{IP_WIDTH{w_in[IP_WIDTH-1]}}, w_in});
        prod_u   = {{IP_WIDTH{1'b0}}, x_in} * {{IP_WIDTH{1'b0}}, w_in};
        prod_ext = mode_signed ? OP_WIDTH'(prod_s) : OP_WIDTH'(prod_u);
`ifdef SYSTOLIC_SAT_EN
        acc_nxt  = OP_WIDTH'(sat_add(mode_signed ? 64'($signed(acc)) : 64'(acc),
                                     mode_signed ? 64'($signed(prod_ext)) : 64'(prod_ext),
                                     mode_signed, OP_WIDTH));
`else
        acc_nxt  = acc + prod_ext;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_out   <= '0;
            w_out   <= '0;
            en_out  <= 1'b0;
            clr_out <= 1'b0;
            acc     <= '0;
        end else begin
            x_out   <= x_in;
            w_out   <= w_in;
            en_out  <= en_in;
            clr_out <= clr_in;
            // A clr token starts a new tile: load the product rather than accumulate
            if (en_in)
                acc <= clr_in ? prod_ext : acc_nxt;
        end
    end

endmodule

// File: rtl/systolic_tile_engine.sv
// Self-sequencing ROWSxCOLS output-stationary MAC tile with operand stream,
// row-serial drain and optional saturation (SYSTOLIC_SAT_EN).
module systolic_tile_engine
    import systolic_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int IP_WIDTH = 8,
    parameter int OP_WIDTH = 32,
    parameter int K_MAX    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] cfg_k,
    input  logic                       cfg_signed,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*IP_WIDTH-1:0]   in_x,
    input  logic [COLS*IP_WIDTH-1:0]   in_w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(ROWS)-1:0]    out_row,
    output logic [COLS*OP_WIDTH-1:0]   out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [31:0]                cycles_count
);

    localparam int KW      = $clog2(K_MAX + 1);
    localparam int RW      = $clog2(ROWS);
    localparam int FLUSH_N = flush_cycles(ROWS, COLS);
    localparam int FW      = $clog2(FLUSH_N + 1);

    tile_state_t   state;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] beat_cnt;
    logic          sgn;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_q;
    logic          err_q;
    logic [31:0]   cyc_q;

    logic beat;
    logic last_beat;
    logic clr_tok;
    logic cfg_ok;

    assign in_ready     = (state == ST_LOAD);
    assign out_valid    = (state == ST_DRAIN);
    assign busy         = (state != ST_IDLE);
    assign out_row      = row_q;
    assign err          = err_q;
    assign cycles_count = cyc_q;

    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (beat_cnt == k_lat - KW'(1));
    assign clr_tok   = beat && (beat_cnt == '0);
    assign cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
    assign done      = (state == ST_DRAIN) && out_ready && (row_q == RW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            sgn       <= 1'b0;
            flush_cnt <= '0;
            row_q     <= '0;
            err_q     <= 1'b0;
            cyc_q     <= '0;
        end else begin
            err_q <= 1'b0;
            if (busy)
                cyc_q <= cyc_q + 32'd1;
            case (state)
                ST_IDLE: begin
                    if (start && cfg_ok) begin
                        k_lat    <= cfg_k;
                        sgn      <= cfg_signed;
                        beat_cnt <= '0;
                        cyc_q    <= '0;
                        state    <= ST_LOAD;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (beat)
                        beat_cnt <= beat_cnt + KW'(1);
                    if (last_beat) begin
                        flush_cnt <= '0;
                        state     <= ST_FLUSH;
                    end
                end
                // Let the last beat ripple through to PE[ROWS-1][COLS-1]
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + FW'(1);
                    if (flush_cnt == FW'(FLUSH_N - 1)) begin
                        row_q <= '0;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            row_q <= '0;
                            state <= ST_IDLE;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [IP_WIDTH-1:0] xg [ROWS][COLS+1];
    logic                eg [ROWS][COLS+1];
    logic                cg [ROWS][COLS+1];
    logic [IP_WIDTH-1:0] wg [ROWS+1][COLS];
    logic [OP_WIDTH-1:0] accg [ROWS][COLS];

    // Row i operands and tokens are delayed i cycles before entering column 0
    for (genvar i = 0; i < ROWS; i++) begin : g_xskew
        if (i == 0) begin : g_direct
            assign xg[0][0] = in_x[IP_WIDTH-1:0];
            assign eg[0][0] = beat;
            assign cg[0][0] = clr_tok;
        end else begin : g_dly
            logic [IP_WIDTH-1:0] x_d [i];
            logic                e_d [i];
            logic                c_d [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        x_d[k] <= '0;
                        e_d[k] <= 1'b0;
                        c_d[k] <= 1'b0;
                    end
                end else begin
                    x_d[0] <= in_x[(i+1)*IP_WIDTH-1 -: IP_WIDTH];
                    e_d[0] <= beat;
                    c_d[0] <= clr_tok;
                    for (int k = 1; k < i; k++) begin
                        x_d[k] <= x_d[k-1];
                        e_d[k] <= e_d[k-1];
                        c_d[k] <= c_d[k-1];
                    end
                end
            end
            assign xg[i][0] = x_d[i-1];
            assign eg[i][0] = e_d[i-1];
            assign cg[i][0] = c_d[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_wskew
        if (j == 0) begin : g_direct
            assign wg[0][0] = in_w[IP_WIDTH-1:0];
        end else begin : g_dly
            logic [IP_WIDTH-1:0] w_d [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < j; k++)
                        w_d[k] <= '0;
                end else begin
                    w_d[0] <= in_w[(j+1)*IP_WIDTH-1 -: IP_WIDTH];
                    for (int k = 1; k < j; k++)
                        w_d[k] <= w_d[k-1];
                end
            end
            assign wg[0][j] = w_d[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            tile_pe #(
                .IP_WIDTH(IP_WIDTH),
                .OP_WIDTH(OP_WIDTH)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .mode_signed(sgn),
                .x_in       (xg[i][j]),
                .w_in       (wg[i][j]),
                .en_in      (eg[i][j]),
                .clr_in     (cg[i][j]),
                .x_out      (xg[i][j+1]),
                .w_out      (wg[i+1][j]),
                .en_out     (eg[i][j+1]),
                .clr_out    (cg[i][j+1]),
                .acc        (accg[i][j])
            );
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < COLS; j++)
            out_data[j*OP_WIDTH +: OP_WIDTH] = accg[row_q][j];
    end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Bench for systolic_tile_engine: a 32-bit instance plus a 16-bit instance
// sharing the same stimulus; SYSTOLIC_SAT_EN selects the narrow expectation.
module tb_systolic_tile_engine;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int IP = 8;
    localparam int OP = 32;
    localparam int KM = 16;
`ifdef SYSTOLIC_SAT_EN
    localparam logic [15:0] NARROW_EXP = 16'h7FFF;
`else
    localparam logic [15:0] NARROW_EXP = 16'hFC04;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [4:0]        cfg_k;
    logic              cfg_signed;
    logic              in_valid;
    logic              in_ready;
    logic [R*IP-1:0]   in_x;
    logic [C*IP-1:0]   in_w;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_row;
    logic [C*OP-1:0]   out_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       cycles_count;

    logic              n_in_ready, n_out_valid, n_busy, n_done, n_err;
    logic [1:0]        n_out_row;
    logic [C*16-1:0]   n_out_data;
    logic [31:0]       n_cycles;

    always #5 clk = ~clk;

    systolic_tile_engine #(.ROWS(R), .COLS(C), .IP_WIDTH(IP), .OP_WIDTH(OP), .K_MAX(KM)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
        .busy(busy), .done(done), .err(err), .cycles_count(cycles_count));

    systolic_tile_engine #(.ROWS(R), .COLS(C), .IP_WIDTH(IP), .OP_WIDTH(16), .K_MAX(KM)) dut_n (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_x(in_x), .in_w(in_w),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_row(n_out_row), .out_data(n_out_data),
        .busy(n_busy), .done(n_done), .err(n_err), .cycles_count(n_cycles));

    typedef struct packed {
        int          k;
        logic        sgn;
        logic [31:0] x;
        logic [31:0] w;
        logic        bubbles;
        logic        stall;
        logic        mid_start;
        logic        chk_narrow;
        logic [15:0] exp_narrow;
        int          exp_cycles;
    } vec_t;

    typedef struct packed {
        int           row;
        logic [127:0] data;
    } exp_t;

    exp_t q[$];
    vec_t tbl[7];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    task automatic chk(input string name, input longint act, input longint expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic run_job(input vec_t v);
        int   beats, t, first_ov, done_cyc, stall_left;
        exp_t e;
        logic [7:0] xb, wb;
        longint xv, wv, s;
        for (int r = 0; r < R; r++) begin
            e.row  = r;
            e.data = '0;
            for (int c = 0; c < C; c++) begin
                xb = v.x[r*8 +: 8];
                wb = v.w[c*8 +: 8];
                xv = v.sgn ? longint'($signed(xb)) : longint'(xb);
                wv = v.sgn ? longint'($signed(wb)) : longint'(wb);
                s  = longint'(v.k) * xv * wv;
                e.data[c*32 +: 32] = s[31:0];
            end
            q.push_back(e);
        end
        start = 1'b1; cfg_k = 5'(v.k); cfg_signed = v.sgn; in_valid = 1'b0;
        in_x = v.x; in_w = v.w;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        chk("in_ready_cycle1", longint'(in_ready), 1);
        beats = 0; t = 0;
        while (beats < v.k && t < 200) begin
            in_valid = v.bubbles ? ((t % 5) != 1 && (t % 5) != 4) : 1'b1;
            start    = v.mid_start && (t == 1);
            cfg_k    = (v.mid_start && t == 1) ? 5'd2 : 5'(v.k);
            #1;
            if (in_valid && in_ready) beats++;
            @(posedge clk); #1;
            cyc++; t++;
        end
        in_valid = 1'b0; start = 1'b0;
        chk("beats_accepted", beats, v.k);
        chk("no_over_accept", longint'(in_ready), 0);
        first_ov = -1; done_cyc = -1; stall_left = v.stall ? 3 : 0;
        while (q.size() > 0 && t < 400) begin
            if (v.stall && out_valid && out_row == 2'd1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (!out_ready) begin
                    chk_vec("stall_hold_data", out_data, q[0].data);
                    chk("stall_hold_row", longint'(out_row), q[0].row);
                end else begin
                    e = q.pop_front();
                    chk("row_index", longint'(out_row), e.row);
                    chk_vec("row_data", out_data, e.data);
                    if (v.chk_narrow)
                        for (int c = 0; c < C; c++)
                            chk("narrow_acc", longint'(n_out_data[c*16 +: 16]), longint'(v.exp_narrow));
                    chk("done_pulse", longint'(done), (q.size() == 0) ? 1 : 0);
                    if (q.size() == 0) done_cyc = cyc;
                end
            end
            @(posedge clk); #1;
            cyc++; t++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        out_ready = 1'b1;
        chk("busy_after_job", longint'(busy), 0);
        chk("done_after_job", longint'(done), 0);
        if (v.exp_cycles >= 0) begin
            chk("first_out_valid_cycle", first_ov, v.k + R + C);
            chk("done_cycle", done_cyc, v.exp_cycles);
            chk("cycles_count", longint'(cycles_count), v.exp_cycles);
        end
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_signed = 1'b0;
        in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b1; cyc = 0;

        tbl[0] = '{k:1,  sgn:1'b1, x:32'h01010101, w:32'h02020202, bubbles:1'b0, stall:1'b0,
                   mid_start:1'b0, chk_narrow:1'b0, exp_narrow:16'h0, exp_cycles:12};
        tbl[1] = '{k:1,  sgn:1'b1, x:32'h04030201, w:32'h01010101, bubbles:1'b0, stall:1'b0,
                   mid_start:1'b0, chk_narrow:1'b0, exp_narrow:16'h0, exp_cycles:12};
        tbl[2] = '{k:16, sgn:1'b1, x:32'h80808080, w:32'h80808080, bubbles:1'b0, stall:1'b0,
                   mid_start:1'b0, chk_narrow:1'b0, exp_narrow:16'h0, exp_cycles:27};
        tbl[3] = '{k:16, sgn:1'b0, x:32'hFFFFFFFF, w:32'hFFFFFFFF, bubbles:1'b0, stall:1'b0,
                   mid_start:1'b0, chk_narrow:1'b0, exp_narrow:16'h0, exp_cycles:27};
        tbl[4] = '{k:5,  sgn:1'b1, x:32'h04FD0201, w:32'h01FF0302, bubbles:1'b1, stall:1'b1,
                   mid_start:1'b0, chk_narrow:1'b0, exp_narrow:16'h0, exp_cycles:-1};
        tbl[5] = '{k:3,  sgn:1'b0, x:32'h05060708, w:32'h01020304, bubbles:1'b0, stall:1'b0,
                   mid_start:1'b1, chk_narrow:1'b0, exp_narrow:16'h0, exp_cycles:14};
        tbl[6] = '{k:4,  sgn:1'b1, x:32'h7F7F7F7F, w:32'h7F7F7F7F, bubbles:1'b0, stall:1'b0,
                   mid_start:1'b0, chk_narrow:1'b1, exp_narrow:NARROW_EXP, exp_cycles:15};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done_err", longint'({done, err}), 0);
        chk("rst_out_row", longint'(out_row), 0);
        chk_vec("rst_out_data", out_data, '0);
        chk("rst_cycles", longint'(cycles_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Rejected requests
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; cfg_k = (i == 0) ? 5'd0 : 5'd17;
            @(posedge clk); #1;
            start = 1'b0;
            chk("illegal_err_pulse", longint'(err), 1);
            chk("illegal_busy", longint'(busy), 0);
            chk("illegal_no_done", longint'(done), 0);
            @(posedge clk); #1;
            chk("illegal_err_clear", longint'(err), 0);
        end

        // Reset while a job is parked in DRAIN
        start = 1'b1; cfg_k = 5'd1; cfg_signed = 1'b1;
        in_x = 32'h09090909; in_w = 32'h07070707;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        chk("reach_drain", longint'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk_vec("midrst_out_data", out_data, '0);
        chk("midrst_cycles", longint'(cycles_count), 0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            run_job(tbl[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
